// File: rtl/iob_cpu_bus_merge_pkg.sv
// iob_cpu_bus_merge_pkg
// Shared definitions for the CPU bus merger: IOb request/response widths,
// bit positions of each field inside the packed buses, and source IDs.
//
// Request layout  (MSB..LSB): {avalid, addr, wdata, wstrb}
// Response layout (MSB..LSB): {rdata, rvalid, ready}
package iob_cpu_bus_merge_pkg;

  // Source identifiers, also the value stored in the read-ID FIFO
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  // Response field positions do not depend on widths
  localparam int READY  = 0;
  localparam int RVALID = 1;
  localparam int RDATA  = 2;

  // The wstrb field always sits at the bottom of the request
  localparam int WSTRB = 0;

  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_w(input int data_w);
    return data_w + 2;
  endfunction

  function automatic int wdata_pos(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int address_pos(input int data_w);
    return data_w / 8 + data_w;
  endfunction

  function automatic int avalid_pos(input int addr_w, input int data_w);
    return data_w / 8 + data_w + addr_w;
  endfunction

endpackage

// File: rtl/iob_merge_id_fifo.sv
// iob_merge_id_fifo
// One-bit-wide synchronous FIFO remembering which bus issued each
// outstanding read. Depth is 2**OUTST_W.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset (flushes the FIFO)
//   cke_i          clock enable; state frozen when low
//   push_i, data_i write data_i at the tail (ignored when full)
//   pop_i          drop the head entry (ignored when empty)
//   head_o         value at the head
//   empty_o/full_o registered occupancy flags
module iob_merge_id_fifo #(
  parameter int OUTST_W = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cke_i,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic head_o,
  output logic empty_o,
  output logic full_o
);

  localparam int DEPTH = 2 ** OUTST_W;
  localparam logic [OUTST_W:0] DEPTH_C = {1'b1, {OUTST_W{1'b0}}};

  logic [DEPTH-1:0]   mem_q;
  logic [OUTST_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OUTST_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OUTST_W:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers are exactly OUTST_W bits wide, so they wrap modulo the depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (cke_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written
  always_ff @(posedge clk_i) begin
    if (cke_i && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/iob_cpu_bus_merge.sv
// iob_cpu_bus_merge
// Merges the CPU instruction bus and data bus into a single IOb native
// memory port. Arbitration is round-robin with the grant locked while the
// granted request is stalled; outstanding reads are tracked in order so each
// rvalid is routed back to the bus that issued the read.
//
// Optional feature: define IOB_CPU_BUS_MERGE_DPRIO_EN for fixed priority
// (dbus wins ties, no last-grant register).
//
// Ports:
//   clk_i, rst_i, cke_i   clock, async active-high reset, clock enable
//   ibus_req/ibus_resp    instruction bus {avalid,addr,wdata,wstrb}/{rdata,rvalid,ready}
//   dbus_req/dbus_resp    data bus, same layout
//   mem_req/mem_resp      merged memory port
//   err_o                 sticky: rvalid seen with no outstanding read
module iob_cpu_bus_merge
  import iob_cpu_bus_merge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int OUTST_W = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cke_i,
  input  logic [req_w(ADDR_W, DATA_W)-1:0] ibus_req,
  output logic [resp_w(DATA_W)-1:0]        ibus_resp,
  input  logic [req_w(ADDR_W, DATA_W)-1:0] dbus_req,
  output logic [resp_w(DATA_W)-1:0]        dbus_resp,
  output logic [req_w(ADDR_W, DATA_W)-1:0] mem_req,
  input  logic [resp_w(DATA_W)-1:0]        mem_resp,
  output logic                             err_o
);

  localparam int REQ_W  = req_w(ADDR_W, DATA_W);
  localparam int AVALID = avalid_pos(ADDR_W, DATA_W);
  localparam int STRB_W = DATA_W / 8;

  logic             ibus_avalid, dbus_avalid;
  logic             grant;
  logic [REQ_W-1:0] sel_req;
  logic             granted_avalid, mem_avalid, mem_ready, mem_rvalid;
  logic             accept, is_read;
  logic             lock_q, lock_d, lock_src_q, lock_src_d;
  logic             err_q, err_d;
  logic             fifo_head, fifo_empty, fifo_full;

  assign ibus_avalid = ibus_req[AVALID];
  assign dbus_avalid = dbus_req[AVALID];
  assign mem_ready   = mem_resp[READY];
  assign mem_rvalid  = mem_resp[RVALID];

`ifdef IOB_CPU_BUS_MERGE_DPRIO_EN
  always_comb begin
    grant = SRC_I;
    if (lock_q)                           grant = lock_src_q;
    else if (ibus_avalid && !dbus_avalid) grant = SRC_I;
    else if (dbus_avalid)                 grant = SRC_D;
  end
`else
  logic last_grant_q;

  // On a tie the bus that did not win the previous acceptance goes next
  always_comb begin
    grant = SRC_I;
    if (lock_q)                           grant = lock_src_q;
    else if (ibus_avalid && !dbus_avalid) grant = SRC_I;
    else if (dbus_avalid && !ibus_avalid) grant = SRC_D;
    else if (ibus_avalid && dbus_avalid)  grant = (last_grant_q == SRC_D) ? SRC_I : SRC_D;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                last_grant_q <= SRC_D;
    else if (cke_i && accept) last_grant_q <= grant;
  end
`endif

  assign sel_req        = (grant == SRC_D) ? dbus_req : ibus_req;
  assign granted_avalid = sel_req[AVALID];
  // full is registered, so a pop this cycle only frees a slot next cycle
  assign mem_avalid     = granted_avalid & ~fifo_full;
  assign accept         = mem_avalid & mem_ready;
  assign is_read        = (sel_req[WSTRB +: STRB_W] == '0);

  always_comb begin
    mem_req         = sel_req;
    mem_req[AVALID] = mem_avalid;
  end

  // rdata goes to both buses; rvalid only to the bus at the FIFO head
  always_comb begin
    ibus_resp                    = '0;
    dbus_resp                    = '0;
    ibus_resp[RDATA +: DATA_W]   = mem_resp[RDATA +: DATA_W];
    dbus_resp[RDATA +: DATA_W]   = mem_resp[RDATA +: DATA_W];
    ibus_resp[READY]             = (grant == SRC_I) & mem_ready & ~fifo_full;
    dbus_resp[READY]             = (grant == SRC_D) & mem_ready & ~fifo_full;
    ibus_resp[RVALID]            = mem_rvalid & ~fifo_empty & (fifo_head == SRC_I);
    dbus_resp[RVALID]            = mem_rvalid & ~fifo_empty & (fifo_head == SRC_D);
  end

  // A stalled grant is held; dropping avalid while locked releases the lock
  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (accept) begin
      lock_d = 1'b0;
    end else if (granted_avalid) begin
      lock_d     = 1'b1;
      lock_src_d = grant;
    end else begin
      lock_d = 1'b0;
    end
  end

  assign err_d = err_q | (mem_rvalid & fifo_empty);
  assign err_o = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_I;
      err_q      <= 1'b0;
    end else if (cke_i) begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      err_q      <= err_d;
    end
  end

  iob_merge_id_fifo #(
    .OUTST_W(OUTST_W)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cke_i  (cke_i),
    .push_i (accept & is_read),
    .data_i (grant),
    .pop_i  (mem_rvalid),
    .head_o (fifo_head),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

endmodule

// File: tb/tb_iob_cpu_bus_merge.sv
// tb_iob_cpu_bus_merge
// Self-checking bench for iob_cpu_bus_merge (ADDR_W=DATA_W=32, OUTST_W=1).
// A reference model built from queues and plain flags predicts grants,
// readies, rvalid routing and err_o every cycle. Directed scenarios are
// followed by a randomized phase with requesters and a memory responder.
// Honours IOB_CPU_BUS_MERGE_DPRIO_EN for the expected arbitration.
module tb_iob_cpu_bus_merge;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cke;
  logic        iAv, dAv;
  logic [31:0] iAddr, dAddr, iWdata, dWdata;
  logic [3:0]  iWstrb, dWstrb;
  logic        mReady, mRvalid;
  logic [31:0] mRdata;

  logic [68:0] ibusReq, dbusReq, memReq;
  logic [33:0] ibusResp, dbusResp, memResp;
  logic        errO;

  assign ibusReq = {iAv, iAddr, iWdata, iWstrb};
  assign dbusReq = {dAv, dAddr, dWdata, dWstrb};
  assign memResp = {mRdata, mRvalid, mReady};

  logic        memAvO;
  logic [31:0] memAddrO, memWdataO;
  logic [3:0]  memWstrbO;
  logic [31:0] iRdataO, dRdataO;
  logic        iRvalidO, iReadyO, dRvalidO, dReadyO;

  assign {memAvO, memAddrO, memWdataO, memWstrbO} = memReq;
  assign {iRdataO, iRvalidO, iReadyO} = ibusResp;
  assign {dRdataO, dRvalidO, dReadyO} = dbusResp;

  iob_cpu_bus_merge #(
    .ADDR_W (32),
    .DATA_W (32),
    .OUTST_W(1)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .cke_i    (cke),
    .ibus_req (ibusReq),
    .ibus_resp(ibusResp),
    .dbus_req (dbusReq),
    .dbus_resp(dbusResp),
    .mem_req  (memReq),
    .mem_resp (memResp),
    .err_o    (errO)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: 0 = ibus, 1 = dbus
  bit          lockM, lockSrcM, lastM, errM;
  bit          idQ[$];
  logic [31:0] memQ[$];
  bit          accI, accD, pushed;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit expGrant();
    if (lockM) return lockSrcM;
    if (iAv && !dAv) return 1'b0;
    if (dAv && !iAv) return 1'b1;
    if (iAv && dAv) begin
`ifdef IOB_CPU_BUS_MERGE_DPRIO_EN
      return 1'b1;
`else
      return !lastM;
`endif
    end
    return 1'b0;
  endfunction

  task automatic resetModel();
    lockM = 0; lockSrcM = 0; lastM = 1; errM = 0;
    idQ.delete();
    memQ.delete();
  endtask

  task automatic applyStimulus(input bit iav, input logic [31:0] ia, input logic [3:0] iw,
                               input bit dav, input logic [31:0] da, input logic [3:0] dw,
                               input bit rdy, input bit rv, input logic [31:0] rd);
    iAv = iav; iAddr = ia; iWstrb = iw; iWdata = $urandom;
    dAv = dav; dAddr = da; dWstrb = dw; dWdata = $urandom;
    mReady = rdy; mRvalid = rv; mRdata = rd;
  endtask

  // Compare all visible outputs against the model, clock once, advance model
  task automatic runCycle();
    bit g, gv, full, acc, hasHead, head;
    #1;
    full    = (idQ.size() >= DEPTH);
    g       = expGrant();
    gv      = g ? dAv : iAv;
    hasHead = (idQ.size() > 0);
    head    = hasHead ? idQ[0] : 1'b0;
    checkOutput("mem_avalid", memAvO, gv && !full);
    if (gv && !full) begin
      checkOutput("mem_addr", memAddrO, g ? dAddr : iAddr);
      checkOutput("mem_wdata", memWdataO, g ? dWdata : iWdata);
      checkOutput("mem_wstrb", memWstrbO, g ? dWstrb : iWstrb);
    end
    if (iAv) checkOutput("ibus_ready", iReadyO, !g && mReady && !full);
    if (dAv) checkOutput("dbus_ready", dReadyO, g && mReady && !full);
    checkOutput("ibus_rvalid", iRvalidO, mRvalid && hasHead && !head);
    checkOutput("dbus_rvalid", dRvalidO, mRvalid && hasHead && head);
    checkOutput("ibus_rdata", iRdataO, mRdata);
    checkOutput("dbus_rdata", dRdataO, mRdata);
    checkOutput("err", errO, errM);
    acc    = gv && !full && mReady;
    accI   = acc && !g && cke;
    accD   = acc && g && cke;
    pushed = acc && cke && ((g ? dWstrb : iWstrb) == 4'h0);
    @(posedge clk);
    if (cke && !rst) begin
      if (mRvalid) begin
        if (hasHead) idQ.delete(0);
        else errM = 1;
      end
      if (pushed) idQ.push_back(g);
      if (acc) begin
        lockM = 0;
        lastM = g;
      end else if (gv) begin
        lockM    = 1;
        lockSrcM = g;
      end else begin
        lockM = 0;
      end
    end
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cke = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    resetModel();
  endtask

  initial begin
    bit iAct, dAct;
    logic [31:0] stallAddr;
    rst = 1; cke = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetModel();

    // Reset state and a simple ibus read routed back to ibus
    doReset();
    checkOutput("reset_avalid", memAvO, 1'b0);
    checkOutput("reset_err", errO, 1'b0);
    runCycle();
    applyStimulus(1, 32'h100, 4'h0, 0, 0, 0, 1, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF);
    runCycle();

    // Tie-breaking with both buses writing every cycle
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 32'h1000 + k, 4'hF, 1, 32'h2000 + k, 4'hF, 1, 0, 0);
      runCycle();
`ifdef IOB_CPU_BUS_MERGE_DPRIO_EN
      checkOutput("tie_grant_d", accD, 1'b1);
`else
      checkOutput("tie_grant_d", accD, (k % 2) == 1);
`endif
    end

    // Stall: grant and address held while memory is not ready
    doReset();
`ifdef IOB_CPU_BUS_MERGE_DPRIO_EN
    stallAddr = 32'h300;
`else
    stallAddr = 32'h200;
`endif
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 32'h200, 4'h0, 1, 32'h300, 4'hF, 0, 0, 0);
      runCycle();
      checkOutput("stall_addr", memAddrO, stallAddr);
    end
    applyStimulus(1, 32'h200, 4'h0, 1, 32'h300, 4'hF, 1, 0, 0);
    runCycle();
    applyStimulus(!accI, 32'h200, 4'h0, !accD, 32'h300, 4'hF, 1, 0, 0);
    runCycle();

    // FIFO full blocks the third request until one cycle after a pop
    doReset();
    applyStimulus(1, 32'h400, 4'h0, 0, 0, 0, 1, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 1, 32'h404, 4'h0, 1, 0, 0);
    runCycle();
    applyStimulus(1, 32'h408, 4'h0, 0, 0, 0, 1, 0, 0);
    runCycle();
    checkOutput("full_block", memAvO, 1'b0);
    applyStimulus(1, 32'h408, 4'h0, 0, 0, 0, 1, 1, 32'h11);
    runCycle();
    applyStimulus(1, 32'h408, 4'h0, 0, 0, 0, 1, 1, 32'h22);
    runCycle();
    checkOutput("full_release", accI, 1'b1);

    // Write leaves FIFO empty; a stray rvalid then sets the sticky error
    doReset();
    applyStimulus(0, 0, 0, 1, 32'h500, 4'hF, 1, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h33);
    runCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      runCycle();
    end
    checkOutput("err_sticky", errO, 1'b1);
    doReset();
    checkOutput("err_cleared", errO, 1'b0);

    // Asynchronous reset mid-stall with one read outstanding
    applyStimulus(1, 32'h600, 4'h0, 0, 0, 0, 1, 0, 0);
    runCycle();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(0, 0, 0, 1, 32'h700, 4'h0, 0, 0, 0);
      runCycle();
    end
    applyStimulus(1, 32'h604, 4'h0, 1, 32'h700, 4'h0, 1, 1, 32'h44);
    #1;
    rst = 1;
    #1;
    checkOutput("arst_ibus_ready", iReadyO, 1'b1);
    checkOutput("arst_dbus_ready", dReadyO, 1'b0);
    checkOutput("arst_addr", memAddrO, 32'h604);
    checkOutput("arst_ibus_rvalid", iRvalidO, 1'b0);
    checkOutput("arst_dbus_rvalid", dRvalidO, 1'b0);
    checkOutput("arst_err", errO, 1'b0);
    rst = 0;
    resetModel();
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();

    // Randomized traffic against the model
    doReset();
    iAct = 0; dAct = 0;
    for (int n = 0; n < 600; n++) begin
      if (!iAct && $urandom_range(0, 2) == 0) begin
        iAct = 1; iAddr = $urandom; iWdata = $urandom;
        iWstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      if (!dAct && $urandom_range(0, 2) == 0) begin
        dAct = 1; dAddr = $urandom; dWdata = $urandom;
        dWstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      iAv     = iAct;
      dAv     = dAct;
      mReady  = ($urandom_range(0, 3) != 0);
      mRvalid = (memQ.size() > 0) && ($urandom_range(0, 1) == 1);
      mRdata  = mRvalid ? memQ[0] : $urandom;
      cke     = ($urandom_range(0, 9) != 0);
      runCycle();
      if (accI) iAct = 0;
      if (accD) dAct = 0;
      if (cke) begin
        if (mRvalid) memQ.delete(0);
        if (pushed) memQ.push_back($urandom);
      end
    end
    cke = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
